// File: rtl/decodificador_pt2272_param.sv
// PT2262-format trinary word decoder using pulse-width measurement, resynchronised on every rising edge of cod_i.
// D/dv update one clk after the closing sync-gap tick of the confirming word; there is no backpressure, so words arriving while busy are lost.
module decodificador_pt2272_param #(
    parameter int N_ADDR   = 8,
    parameter int N_DATA   = 4,
    parameter int CLK_DIV  = 250,
    parameter int LATCH    = 1,
    parameter int CONFIRM  = 2,
    parameter int SYNC_MIN = 96,
    parameter int TIMEOUT  = 160
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_ADDR-1:0] A_val,
    input  logic [N_ADDR-1:0] A_flt,
    input  logic              cod_i,
    output logic [N_DATA-1:0] D,
    output logic              dv,
    output logic              vt,
    output logic              err
);

    localparam int NSYM  = N_ADDR + N_DATA;
    localparam int TOTAL = 2 * NSYM + 1;
    localparam int PW    = $clog2(TOTAL + 1);
    localparam int SW    = PW - 1;
    localparam int TW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LW    = $clog2(TIMEOUT + 2);
    localparam int HW    = 4;

    typedef enum logic [2:0] {HUNT, WAIT_EDGE, HIGH, LOW, SYNC_CHK, EVAL} state_t;

    state_t              state;
    logic                cod_s1, cod_s2, cod_d;
    logic                rise, fall;
    logic [TW-1:0]       tick_cnt;
    logic                tick_en;
    logic [HW-1:0]       high_cnt, high_nxt;
    logic [LW-1:0]       low_cnt, low_nxt;
    logic [PW-1:0]       pcnt;
    logic [SW-1:0]       sym_idx;
    logic                first_long;
    logic [N_ADDR-1:0]   rx_aval, rx_aflt;
    logic [N_DATA-1:0]   rx_dat, prev_dat;
    logic [2:0]          cnt, cnt_new;
    logic                h_short, h_long, last_pulse, is_data;
    logic                frame_err, timeout, addr_ok, same;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cod_s1   <= 1'b0;
            cod_s2   <= 1'b0;
            cod_d    <= 1'b0;
            tick_cnt <= '0;
            high_cnt <= '0;
            low_cnt  <= '0;
        end else begin
            cod_s1   <= cod_i;
            cod_s2   <= cod_s1;
            cod_d    <= cod_s2;
            tick_cnt <= tick_en ? '0 : tick_cnt + 1'b1;
            high_cnt <= high_nxt;
            low_cnt  <= low_nxt;
        end
    end

    assign rise    = cod_s2 & ~cod_d;
    assign fall    = ~cod_s2 & cod_d;
    assign tick_en = (tick_cnt == TW'(CLK_DIV - 1));

    // Edge clocks seed the counter with their own tick so widths are exact multiples of CLK_DIV.
    always_comb begin
        high_nxt = high_cnt;
        if (rise)
            high_nxt = HW'(tick_en);
        else if (cod_s2 && tick_en && high_cnt != '1)
            high_nxt = high_cnt + 1'b1;

        low_nxt = low_cnt;
        if (rise)
            low_nxt = '0;
        else if (fall)
            low_nxt = LW'(tick_en);
        else if (!cod_s2 && tick_en && low_cnt != LW'(TIMEOUT + 1))
            low_nxt = low_cnt + 1'b1;
    end

    assign h_short    = (high_cnt >= HW'(2)) && (high_cnt <= HW'(7));
    assign h_long     = (high_cnt >= HW'(8)) && (high_cnt <= HW'(14));
    assign sym_idx    = pcnt[PW-1:1];
    assign last_pulse = (pcnt == PW'(TOTAL - 1));
    assign is_data    = (sym_idx >= SW'(N_ADDR));
    assign timeout    = (low_cnt > LW'(TIMEOUT));

    always_comb begin
        frame_err = 1'b0;
        case (state)
            HIGH: begin
                if (fall) begin
                    if (!(h_short || h_long))
                        frame_err = 1'b1;
                    else if (last_pulse)
                        frame_err = !h_short;
                    else if (pcnt[0])
                        frame_err = (first_long && h_short) || (is_data && !first_long && h_long);
                end else if (high_cnt == '1) begin
                    frame_err = 1'b1;
                end
            end
            LOW:      frame_err = (pcnt != PW'(TOTAL)) && (low_cnt > LW'(28));
            SYNC_CHK: frame_err = rise;
            default:  frame_err = 1'b0;
        endcase
    end

    always_comb begin
        addr_ok = 1'b1;
        for (int i = 0; i < N_ADDR; i++) begin
            if (A_flt[i]) begin
                if (!rx_aflt[i]) addr_ok = 1'b0;
            end else if (rx_aflt[i] || (rx_aval[i] != A_val[i])) begin
                addr_ok = 1'b0;
            end
        end

        same = (cnt != 3'd0) && (rx_dat == prev_dat);
        if (!same)
            cnt_new = 3'd1;
        else if (cnt >= 3'(CONFIRM))
            cnt_new = 3'(CONFIRM);
        else
            cnt_new = cnt + 3'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= HUNT;
            pcnt       <= '0;
            first_long <= 1'b0;
            rx_aval    <= '0;
            rx_aflt    <= '0;
            rx_dat     <= '0;
            prev_dat   <= '0;
            cnt        <= '0;
            D          <= '0;
            dv         <= 1'b0;
            vt         <= 1'b0;
            err        <= 1'b0;
        end else begin
            dv  <= 1'b0;
            err <= 1'b0;
            case (state)
                HUNT: if (!cod_s2 && low_cnt >= LW'(SYNC_MIN)) state <= WAIT_EDGE;
                WAIT_EDGE: if (rise) begin
                    state <= HIGH;
                    pcnt  <= '0;
                end
                HIGH: if (fall) begin
                    pcnt  <= pcnt + 1'b1;
                    state <= LOW;
                    if (!pcnt[0]) begin
                        first_long <= h_long;
                    end else begin
                        for (int i = 0; i < N_ADDR; i++)
                            if (sym_idx == SW'(i)) begin
                                rx_aval[i] <= first_long;
                                rx_aflt[i] <= !first_long && h_long;
                            end
                        // Data arrives MSB first, right after the address.
                        for (int j = 0; j < N_DATA; j++)
                            if (sym_idx == SW'(NSYM - 1 - j)) rx_dat[j] <= h_long;
                    end
                end
                LOW: begin
                    if (pcnt == PW'(TOTAL))
                        state <= SYNC_CHK;
                    else if (rise)
                        state <= HIGH;
                end
                SYNC_CHK: if (low_nxt >= LW'(SYNC_MIN)) state <= EVAL;
                EVAL: begin
                    state <= WAIT_EDGE;
                    if (!addr_ok) begin
                        cnt <= '0;
                        vt  <= 1'b0;
                        if (LATCH == 0) D <= '0;
                    end else begin
                        prev_dat <= rx_dat;
                        cnt      <= cnt_new;
                        if (cnt_new == 3'(CONFIRM)) begin
                            vt <= 1'b1;
                            D  <= rx_dat;
                            if (!vt || (D != rx_dat)) dv <= 1'b1;
                        end
                    end
                end
                default: state <= HUNT;
            endcase

            if (frame_err) begin
                err   <= 1'b1;
                cnt   <= '0;
                vt    <= 1'b0;
                state <= HUNT;
                if (LATCH == 0) D <= '0;
            end
            if (timeout) begin
                vt  <= 1'b0;
                cnt <= '0;
                if (LATCH == 0) D <= '0;
            end
        end
    end

endmodule

// File: tb/tb_decodificador_pt2272_param.sv
// Directed bench: three decoder instances (latched, momentary, wide/3-confirm) on one serial line.
`timescale 1ns/1ps
module tb_decodificador_pt2272_param;

    localparam int CD = 2;
    localparam int TK = CD * 10;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, cod;
    logic [7:0] a_val1, a_flt1;
    logic [9:0] a_val3, a_flt3;
    logic [3:0] d1, d2;
    logic [5:0] d3;
    logic       dv1, vt1, err1, dv2, vt2, err2, dv3, vt3, err3;

    int total = 0;
    int bad   = 0;
    int dv1_n = 0, err1_n = 0, dv2_n = 0, dv3_n = 0, err3_n = 0, lat_n = 0;

    always #5 clk = ~clk;

    decodificador_pt2272_param #(.CLK_DIV(CD)) u1 (
        .clk(clk), .reset(rst_a), .A_val(a_val1), .A_flt(a_flt1), .cod_i(cod),
        .D(d1), .dv(dv1), .vt(vt1), .err(err1));

    decodificador_pt2272_param #(.CLK_DIV(CD), .LATCH(0)) u2 (
        .clk(clk), .reset(rst_a), .A_val(a_val1), .A_flt(a_flt1), .cod_i(cod),
        .D(d2), .dv(dv2), .vt(vt2), .err(err2));

    decodificador_pt2272_param #(.N_ADDR(10), .N_DATA(6), .CLK_DIV(CD), .CONFIRM(3)) u3 (
        .clk(clk), .reset(rst_b), .A_val(a_val3), .A_flt(a_flt3), .cod_i(cod),
        .D(d3), .dv(dv3), .vt(vt3), .err(err3));

    always @(posedge clk) begin
        if (dv1 === 1'b1)  dv1_n  <= dv1_n + 1;
        if (err1 === 1'b1) err1_n <= err1_n + 1;
        if (dv2 === 1'b1)  dv2_n  <= dv2_n + 1;
        if (dv3 === 1'b1)  dv3_n  <= dv3_n + 1;
        if (err3 === 1'b1) err3_n <= err3_n + 1;
    end

    // Momentary instance must never show data while vt is low.
    always @(negedge clk)
        if (vt2 === 1'b0 && d2 !== 4'h0) lat_n <= lat_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        #(n * TK);
    endtask

    task automatic pulse(input logic lng);
        cod = 1'b1;
        #((lng ? 12 : 4) * TK);
        cod = 1'b0;
        #((lng ? 4 : 12) * TK);
    endtask

    task automatic send_word(input logic [11:0] av, input logic [11:0] af, input int na,
                             input logic [7:0] dat, input int nd, input int bad_sym, input int stop_after);
        for (int i = 0; i < na; i++) begin
            if (i == stop_after) return;
            if (i == bad_sym) begin
                pulse(1'b1); pulse(1'b0);
            end else if (af[i]) begin
                pulse(1'b0); pulse(1'b1);
            end else begin
                pulse(av[i]); pulse(av[i]);
            end
        end
        for (int j = nd - 1; j >= 0; j--) begin
            pulse(dat[j]); pulse(dat[j]);
        end
        cod = 1'b1;
        ticks(4);
        cod = 1'b0;
        ticks(124);
    endtask

    initial begin
        int b1, b2, be, b3, be3;
        cod    = 1'b0;
        rst_a  = 1'b0;
        rst_b  = 1'b0;
        a_val1 = 8'b1010_0000;
        a_flt1 = 8'h00;
        a_val3 = 10'h261;
        a_flt3 = 10'h010;
        @(negedge clk);
        ticks(2);
        chk("rst_d1", d1, 0);
        chk("rst_dv1", dv1, 0);
        chk("rst_vt1", vt1, 0);
        chk("rst_err1", err1, 0);
        chk("rst_vt3", vt3, 0);

        // Confirmation, repeat and timeout on latched/momentary instances.
        rst_a = 1'b1;
        b1 = dv1_n; b2 = dv2_n; be = err1_n;
        ticks(110);
        send_word(12'h0A0, 12'h000, 8, 8'h0B, 4, -1, 99);
        chk("w1_dv1", dv1_n - b1, 0);
        chk("w1_vt1", vt1, 0);
        chk("w1_dv2", dv2_n - b2, 0);
        send_word(12'h0A0, 12'h000, 8, 8'h0B, 4, -1, 99);
        chk("w2_dv1", dv1_n - b1, 1);
        chk("w2_d1", d1, 4'hB);
        chk("w2_vt1", vt1, 1);
        chk("w2_dv2", dv2_n - b2, 1);
        chk("w2_d2", d2, 4'hB);
        send_word(12'h0A0, 12'h000, 8, 8'h0B, 4, -1, 99);
        chk("w3_dv1", dv1_n - b1, 1);
        chk("w3_vt1", vt1, 1);
        ticks(33);
        chk("idle157_vt1", vt1, 1);
        ticks(8);
        chk("idle165_vt1", vt1, 0);
        chk("idle165_d1", d1, 4'hB);
        chk("idle165_vt2", vt2, 0);
        chk("idle165_d2", d2, 4'h0);
        ticks(35);
        chk("idle200_dv1", dv1_n - b1, 1);
        chk("lat0_clear", lat_n, 0);
        chk("a_err1", err1_n - be, 0);

        // Floating address symbol accepted.
        rst_a  = 1'b0;
        a_flt1 = 8'h08;
        ticks(2);
        rst_a = 1'b1;
        b1 = dv1_n; be = err1_n;
        ticks(110);
        send_word(12'h0A0, 12'h008, 8, 8'h06, 4, -1, 99);
        send_word(12'h0A0, 12'h008, 8, 8'h06, 4, -1, 99);
        chk("flt_dv1", dv1_n - b1, 1);
        chk("flt_d1", d1, 4'h6);
        chk("flt_vt1", vt1, 1);
        chk("flt_err1", err1_n - be, 0);

        // Driven 0 where F is expected is a silent mismatch.
        rst_a = 1'b0;
        ticks(2);
        rst_a = 1'b1;
        b1 = dv1_n; be = err1_n;
        ticks(110);
        send_word(12'h0A0, 12'h000, 8, 8'h06, 4, -1, 99);
        send_word(12'h0A0, 12'h000, 8, 8'h06, 4, -1, 99);
        chk("mis_dv1", dv1_n - b1, 0);
        chk("mis_vt1", vt1, 0);
        chk("mis_err1", err1_n - be, 0);

        // long,short pair at A5 then recovery.
        rst_a  = 1'b0;
        a_flt1 = 8'h00;
        ticks(2);
        rst_a = 1'b1;
        b1 = dv1_n; be = err1_n;
        ticks(110);
        send_word(12'h0A0, 12'h000, 8, 8'h0B, 4, 5, 99);
        chk("bad_err1", err1_n - be, 1);
        chk("bad_vt1", vt1, 0);
        chk("bad_dv1", dv1_n - b1, 0);
        send_word(12'h0A0, 12'h000, 8, 8'h0B, 4, -1, 99);
        send_word(12'h0A0, 12'h000, 8, 8'h0B, 4, -1, 99);
        chk("rec_dv1", dv1_n - b1, 1);
        chk("rec_d1", d1, 4'hB);
        chk("rec_vt1", vt1, 1);
        chk("rec_err1", err1_n - be, 1);

        // Wide instance, three-word confirmation, reset mid-word.
        rst_a = 1'b0;
        rst_b = 1'b1;
        b3 = dv3_n; be3 = err3_n;
        ticks(110);
        send_word(12'h261, 12'h010, 10, 8'h2D, 6, -1, 99);
        send_word(12'h261, 12'h010, 10, 8'h2D, 6, -1, 99);
        chk("c3_w2_dv3", dv3_n - b3, 0);
        chk("c3_w2_vt3", vt3, 0);
        send_word(12'h261, 12'h010, 10, 8'h2D, 6, -1, 99);
        chk("c3_w3_dv3", dv3_n - b3, 1);
        chk("c3_w3_d3", d3, 6'h2D);
        chk("c3_w3_vt3", vt3, 1);
        chk("c3_err3", err3_n - be3, 0);
        send_word(12'h261, 12'h010, 10, 8'h2D, 6, -1, 99);
        chk("c3_w4_dv3", dv3_n - b3, 1);
        send_word(12'h261, 12'h010, 10, 8'h2D, 6, -1, 4);
        rst_b = 1'b0;
        ticks(2);
        chk("mid_rst_d3", d3, 6'h00);
        chk("mid_rst_vt3", vt3, 0);
        chk("mid_rst_dv3", dv3, 0);
        rst_b = 1'b1;
        b3 = dv3_n;
        ticks(110);
        send_word(12'h261, 12'h010, 10, 8'h2D, 6, -1, 99);
        send_word(12'h261, 12'h010, 10, 8'h2D, 6, -1, 99);
        chk("post_w2_dv3", dv3_n - b3, 0);
        chk("post_w2_vt3", vt3, 0);
        send_word(12'h261, 12'h010, 10, 8'h2D, 6, -1, 99);
        chk("post_w3_dv3", dv3_n - b3, 1);
        chk("post_w3_d3", d3, 6'h2D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
